// File: rtl/tram_spi_streamer_pkg.sv
// Shared types and constants for the tRAM-to-SPI frame streamer.
// State encoding, SPI mode (mode 0, MSB first) and default frame size.
package tram_spi_streamer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR  = 3'd1,
      ST_LATCH = 3'd2,
      ST_SHIFT = 3'd3,
      ST_FIN   = 3'd4
   } state_t;

   localparam logic SPI_CPOL      = 1'b0;
   localparam logic SPI_CPHA      = 1'b0;
   localparam logic SPI_MSB_FIRST = 1'b1;

   localparam int DEFAULT_NUM_BYTES = 16;
   localparam int DEFAULT_CLK_DIV   = 16;
   localparam int BITS_PER_BYTE     = 8;

endpackage

// File: rtl/tram_spi_streamer_spi_tick_gen.sv
// Half-bit tick generator: one-clk tick every CLK_DIV clocks while enabled.
// Counter is held at 0 when disabled, so the first tick lands CLK_DIV clocks after enable rises.
module tram_spi_streamer_spi_tick_gen
   import tram_spi_streamer_pkg::*;
#(
   parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == TERM);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (!en || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/tram_spi_streamer.sv
// Reads NUM_BYTES bytes from a sync-read tRAM and shifts them out on SPI mode 0, MSB first.
// One frame per start rising edge: NUM_BYTES*(2+16*CLK_DIV)+2 clk to done; start edges while busy are ignored.
module tram_spi_streamer
   import tram_spi_streamer_pkg::*;
#(
   parameter int CLK_DIV   = DEFAULT_CLK_DIV,
   parameter int NUM_BYTES = DEFAULT_NUM_BYTES,
   parameter int ADDR_W    = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        rd_data,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              sclk,
   output logic              mosi,
   output logic              cs_n,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BYTES - 1);
   localparam logic [2:0]        LAST_BIT  = 3'(BITS_PER_BYTE - 1);

   state_t     state, state_nxt;
   logic       start_q, armed, start_edge;
   logic       tick, lead_evt, byte_end;
   logic [7:0] shift_reg;
   logic [2:0] bit_cnt;

   // armed stays low after reset until start is seen low, so a level held across reset release cannot fire
   assign start_edge = start && !start_q && armed;

   tram_spi_streamer_spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_spi_tick_gen (
      .clk   (clk),
      .reset (reset),
      .en    (state == ST_SHIFT),
      .tick  (tick)
   );

   assign lead_evt = tick && (sclk == (SPI_CPOL ^ SPI_CPHA));
   assign byte_end = tick && !lead_evt && (bit_cnt == LAST_BIT);
   assign mosi     = (state == ST_SHIFT) ? (SPI_MSB_FIRST ? shift_reg[7] : shift_reg[0]) : 1'b0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:  if (start_edge) state_nxt = ST_ADDR;
         ST_ADDR:  state_nxt = ST_LATCH;
         ST_LATCH: state_nxt = ST_SHIFT;
         ST_SHIFT: if (byte_end) state_nxt = (rd_addr == LAST_ADDR) ? ST_FIN : ST_ADDR;
         ST_FIN:   state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_addr   <= '0;
         sclk      <= SPI_CPOL;
         cs_n      <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         shift_reg <= '0;
         bit_cnt   <= '0;
         start_q   <= 1'b0;
         armed     <= 1'b0;
      end else begin
         start_q <= start;
         armed   <= armed | ~start;
         done    <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               sclk <= SPI_CPOL;
               if (start_edge) begin
                  rd_addr <= '0;
                  cs_n    <= 1'b0;
                  busy    <= 1'b1;
               end
            end
            ST_LATCH: begin
               shift_reg <= rd_data;
               bit_cnt   <= '0;
            end
            ST_SHIFT: begin
               // leading edge samples; trailing edge advances to the next bit or byte
               if (lead_evt) begin
                  sclk <= ~SPI_CPOL;
               end else if (tick) begin
                  sclk <= SPI_CPOL;
                  if (!byte_end) begin
                     shift_reg <= SPI_MSB_FIRST ? {shift_reg[6:0], 1'b0} : {1'b0, shift_reg[7:1]};
                     bit_cnt   <= bit_cnt + 3'd1;
                  end else if (rd_addr != LAST_ADDR) begin
                     rd_addr <= rd_addr + ADDR_W'(1);
                  end
               end
            end
            ST_FIN: begin
               cs_n <= 1'b1;
               busy <= 1'b0;
               done <= 1'b1;
               sclk <= SPI_CPOL;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tram_spi_streamer.sv
// Bench for tram_spi_streamer: sync-RAM model, SPI slave capture and rule monitors,
// driven with counting, fixed-pattern and random frames on a CLK_DIV=2 and a CLK_DIV=1/1-byte instance.
module tb_tram_spi_streamer;

   localparam int DIV   = 2;
   localparam int NB    = 16;
   localparam int FRAME = NB * (2 + 16 * DIV) + 2;
   localparam int FRAME_SMALL = 1 * (2 + 16 * 1) + 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0, start2 = 1'b0;
   logic [7:0] rd_data = '0, rd_data2 = '0;
   logic [3:0] rd_addr, rd_addr2;
   logic       sclk, mosi, cs_n, busy, done;
   logic       sclk2, mosi2, cs_n2, busy2, done2;

   logic [7:0] ram [16];
   logic [7:0] ram2 = '0;

   int chk_cnt = 0;
   int pass_cnt = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      rd_data  <= ram[rd_addr];
      rd_data2 <= ram2;
   end

   tram_spi_streamer #(.CLK_DIV(DIV), .NUM_BYTES(NB), .ADDR_W(4)) u_dut (
      .clk(clk), .reset(reset), .start(start), .rd_data(rd_data), .rd_addr(rd_addr),
      .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .busy(busy), .done(done)
   );

   tram_spi_streamer #(.CLK_DIV(1), .NUM_BYTES(1), .ADDR_W(4)) u_small (
      .clk(clk), .reset(reset), .start(start2), .rd_data(rd_data2), .rd_addr(rd_addr2),
      .sclk(sclk2), .mosi(mosi2), .cs_n(cs_n2), .busy(busy2), .done(done2)
   );

   // SPI slave and rule monitors, sampled on the falling clk edge
   int         cyc_n = 0;
   logic [7:0] sh = '0, sh2 = '0;
   int         bit_n = 0, bit2 = 0;
   logic [7:0] cap_q [$];
   logic [7:0] cap2_q [$];
   int         done_cnt = 0, mosi_viol = 0, cs_viol = 0, addr_viol = 0;
   int         done2_cnt = 0, per_viol2 = 0, addr2_viol = 0, last_rise2 = 0;
   logic       prev_sclk = 1'b0, prev_mosi = 1'b0, prev_sclk2 = 1'b0;
   logic [3:0] last_addr = '0;

   always @(negedge clk) begin
      cyc_n++;
      if (reset) begin
         bit_n = 0; bit2 = 0;
         prev_sclk = 1'b0; prev_mosi = 1'b0; prev_sclk2 = 1'b0;
         last_addr = '0;
      end else begin
         if (sclk && !prev_sclk && !cs_n) begin
            sh = {sh[6:0], mosi};
            bit_n++;
            if (bit_n == 8) begin
               cap_q.push_back(sh);
               bit_n = 0;
            end
         end
         if (sclk && (mosi !== prev_mosi)) mosi_viol++;
         if ((busy || sclk) && cs_n) cs_viol++;
         if (done) done_cnt++;
         if ((rd_addr != last_addr) && (rd_addr != last_addr + 4'd1)) addr_viol++;
         last_addr = rd_addr;
         prev_sclk = sclk;
         prev_mosi = mosi;

         if (sclk2 && !prev_sclk2 && !cs_n2) begin
            if (bit2 > 0 && (cyc_n - last_rise2) != 2) per_viol2++;
            last_rise2 = cyc_n;
            sh2 = {sh2[6:0], mosi2};
            bit2++;
            if (bit2 == 8) begin
               cap2_q.push_back(sh2);
               bit2 = 0;
            end
         end
         if (done2) done2_cnt++;
         if (rd_addr2 != 4'd0) addr2_viol++;
         prev_sclk2 = sclk2;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // hold_cycles>0 keeps start high that long past done; mid_cyc>0 adds a second start pulse mid-frame
   task automatic run_frame(input string tag, input int hold_cycles, input int mid_cyc);
      int   b_cap, b_done, b_mv, b_cv, b_av, cyc;
      bit   got;
      logic [7:0] cbyte;
      b_cap = cap_q.size(); b_done = done_cnt;
      b_mv = mosi_viol; b_cv = cs_viol; b_av = addr_viol;
      @(posedge clk); #1 start = 1'b1;
      cyc = 0; got = 1'b0;
      while (!got && cyc < 3000) begin
         @(posedge clk); cyc++; #1;
         if (hold_cycles == 0 && cyc == 1) start = 1'b0;
         if (mid_cyc > 0 && cyc == mid_cyc) start = 1'b1;
         if (mid_cyc > 0 && cyc == mid_cyc + 2) start = 1'b0;
         if (done) got = 1'b1;
      end
      chk({tag, "_latency"}, 32'(cyc), 32'(FRAME));
      if (hold_cycles > 0) begin
         repeat (hold_cycles) @(posedge clk);
         #1 chk({tag, "_hold_busy"}, 32'(busy), 32'd0);
         start = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk({tag, "_nbytes"}, 32'(cap_q.size() - b_cap), 32'(NB));
      for (int i = 0; i < NB; i++) begin
         cbyte = (b_cap + i < cap_q.size()) ? cap_q[b_cap + i] : 8'hxx;
         chk($sformatf("%s_byte%0d", tag, i), 32'(cbyte), 32'(ram[i]));
      end
      chk({tag, "_done_cnt"}, 32'(done_cnt - b_done), 32'd1);
      chk({tag, "_mosi_stable"}, 32'(mosi_viol - b_mv), 32'd0);
      chk({tag, "_cs_low"}, 32'(cs_viol - b_cv), 32'd0);
      chk({tag, "_addr_seq"}, 32'(addr_viol - b_av), 32'd0);
      chk({tag, "_end_cs_n"}, 32'(cs_n), 32'd1);
      chk({tag, "_end_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic run_small(input string tag);
      int b_cap, b_done, b_pv, b_av, cyc;
      bit got;
      logic [7:0] cbyte;
      ram2 = 8'($urandom);
      b_cap = cap2_q.size(); b_done = done2_cnt; b_pv = per_viol2; b_av = addr2_viol;
      @(posedge clk); #1 start2 = 1'b1;
      cyc = 0; got = 1'b0;
      while (!got && cyc < 200) begin
         @(posedge clk); cyc++; #1;
         if (cyc == 1) start2 = 1'b0;
         if (done2) got = 1'b1;
      end
      chk({tag, "_latency"}, 32'(cyc), 32'(FRAME_SMALL));
      repeat (3) @(posedge clk);
      #1;
      cbyte = (b_cap < cap2_q.size()) ? cap2_q[b_cap] : 8'hxx;
      chk({tag, "_nbytes"}, 32'(cap2_q.size() - b_cap), 32'd1);
      chk({tag, "_byte"}, 32'(cbyte), 32'(ram2));
      chk({tag, "_sclk_period"}, 32'(per_viol2 - b_pv), 32'd0);
      chk({tag, "_done_cnt"}, 32'(done2_cnt - b_done), 32'd1);
      chk({tag, "_addr"}, 32'(addr2_viol - b_av), 32'd0);
   endtask

   task automatic reset_mid_frame();
      int b_done;
      for (int i = 0; i < 16; i++) ram[i] = 8'($urandom);
      b_done = done_cnt;
      @(posedge clk); #1 start = 1'b1;
      // first edge samples start; byte 7 enters SHIFT after edge 241, bit 3 spans edges 253..256
      repeat (254) @(posedge clk);
      #1 chk("rst_pre_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      chk("rst_cs_n", 32'(cs_n), 32'd1);
      chk("rst_sclk", 32'(sclk), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rd_addr", 32'(rd_addr), 32'd0);
      chk("rst_mosi", 32'(mosi), 32'd0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (20) @(posedge clk);
      #1 chk("rst_held_start_no_fire", 32'(busy), 32'd0);
      chk("rst_no_done", 32'(done_cnt - b_done), 32'd0);
      start = 1'b0;
      repeat (2) @(posedge clk);
      run_frame("post_rst", 0, 0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) ram[i] = 8'(i);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_sclk", 32'(sclk), 32'd0);
      chk("reset_cs_n", 32'(cs_n), 32'd1);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_mosi", 32'(mosi), 32'd0);
      chk("reset_rd_addr", 32'(rd_addr), 32'd0);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("idle_cs_n", 32'(cs_n), 32'd1);

      run_frame("count", 0, 0);

      for (int i = 0; i < 16; i++) begin
         case (i % 4)
            0: ram[i] = 8'hA5;
            1: ram[i] = 8'hFF;
            2: ram[i] = 8'h00;
            default: ram[i] = 8'h80;
         endcase
      end
      run_frame("pattern", 0, 0);

      for (int i = 0; i < 16; i++) ram[i] = 8'($urandom);
      run_frame("hold", FRAME, 0);

      for (int i = 0; i < 16; i++) ram[i] = 8'($urandom);
      run_frame("mid_start", 0, 5 * (2 + 16 * DIV) + 10);

      reset_mid_frame();

      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 16; i++) ram[i] = 8'($urandom);
         run_frame($sformatf("rand%0d", r), 0, 0);
      end

      for (int r = 0; r < 3; r++) run_small($sformatf("small%0d", r));

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", pass_cnt, chk_cnt);
      $fatal(1);
   end

endmodule
